grayscale_rd_sched: RTL and testbench
=====================================

# grayscale_rd_sched

Read-request scheduler for the grayscale AFU. On a start command, it sequences one CCI-P read request per cache line of the source buffer, using the line address and line count taken from the CSR block's buffer registers. It throttles requests on channel-0 almost-full and on a bounded outstanding-read budget, then posts a completion record to the DSM line. It sits between the CSR block and the c0Tx/c1Tx request muxing toward the FIU.

## Interface
- ADDR_W, 42: line-address width (byte address >> 6, same as buffer/DSM registers)
- SIZE_W, 32: line-count width
- MAX_OUTSTANDING, 32: maximum reads in flight (power of two, >= 2)
- TAG_W, $clog2(MAX_OUTSTANDING): request tag width
- clk  in  1  AFU clock; sole clock domain
- reset_n  in  1  synchronous, active-low reset
- start  in  1  one-cycle start pulse (rising edge of the control run bit)
- src_base  in  ADDR_W  source buffer line address, sampled on accepted start
- num_lines  in  SIZE_W  lines to read, sampled on accepted start
- dsm_base  in  ADDR_W  DSM line address, sampled on accepted start
- c0_almfull  in  1  channel-0 request almost-full
- rd_req_valid  out  1  one read request per asserted cycle (no ready)
- rd_req_addr  out  ADDR_W  line address of request
- rd_req_tag  out  TAG_W  issue index modulo MAX_OUTSTANDING
- rd_rsp_valid  in  1  one read response returned this cycle
- wr_done_valid  out  1  completion write request, held until ack
- wr_done_addr  out  ADDR_W  = sampled dsm_base
- wr_done_data  out  SIZE_W  = lines received
- wr_done_ack  in  1  completion write accepted this cycle
- busy  out  1  state != IDLE
- done  out  1  sticky completion flag
- err_unexpected  out  1  sticky: response arrived with zero outstanding

## Operation
- States: IDLE, ISSUE, DRAIN, REPORT.
- IDLE, start=1: latch src_base, num_lines, dsm_base; clear issued, received, outstanding, done. Go to ISSUE, or to REPORT if num_lines==0.
- start is ignored in any state other than IDLE. No error is flagged.
- ISSUE: a request is issued in cycle t when c0_almfull=0 at t, issued<num_lines, and outstanding<MAX_OUTSTANDING.
  - Request: rd_req_addr = src_base + issued (mod 2^ADDR_W), rd_req_tag = issued[TAG_W-1:0].
  - On issue, issued increments.
  - Move to DRAIN when issued reaches num_lines.
- Outstanding counter: +1 on issue, -1 on rd_rsp_valid; both in the same cycle leaves it unchanged.
- rd_rsp_valid increments received in any non-IDLE state.
- rd_rsp_valid with outstanding==0 and no same-cycle issue: set err_unexpected; counters do not change.
- DRAIN: go to REPORT when outstanding==0 and received==num_lines.
- REPORT: assert wr_done_valid with wr_done_data=received; hold until wr_done_ack.
  - On ack: done<=1, return to IDLE.
- reset_n=0 at any clock edge: all state and counters clear on that edge, state returns to IDLE, and any pending request is abandoned.
- Reset values: all outputs 0. rd_req_addr, wr_done_addr and wr_done_data are 0 as well.
- err_unexpected clears only on reset.

## Timing
- Start accepted at edge N: first rd_req_valid visible in cycle N+1, provided c0_almfull=0 in cycle N.
- Request outputs are registered. c0_almfull sampled at edge t gates rd_req_valid in cycle t+1.
- Peak rate: one request per cycle.
- The request budget counts the request being issued in the same cycle, so outstanding never exceeds MAX_OUTSTANDING.
- Response in cycle t is reflected in outstanding at t+1. A freed credit can be used by an issue visible in t+2.
- wr_done_valid rises one cycle after the DRAIN exit condition holds. The ack is sampled at the edge; done is visible the next cycle.
- busy drops in the same cycle done rises.

## Test plan
- src_base=0x1000, num_lines=4, almfull=0, each response 5 cycles after its request -> requests at addr 0x1000..0x1003, tags 0..3 on consecutive cycles; wr_done_valid, addr=dsm_base, data=4; done=1 after ack.
- num_lines=0 -> no rd_req_valid; wr_done_valid one cycle after start with data=0; done after ack.
- MAX_OUTSTANDING=4, num_lines=10, responses withheld -> exactly 4 requests, then stall. Release one response -> exactly one further request two cycles later.
- c0_almfull high for 3 cycles mid-ISSUE -> no request during the cycles it gates; issue resumes with the next contiguous address; total 8 requests for num_lines=8.
- rd_rsp_valid pulsed while IDLE -> err_unexpected=1 and stays set; second start while busy -> ignored, latched num_lines unchanged.
- reset_n low during DRAIN with 3 outstanding -> next cycle all outputs 0, busy=0; a new start then runs a clean 2-line transfer.

Source files
------------

// File: rtl/grayscale_rd_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : grayscale_rd_sched_if
// Description : CSR/request/response bundle between the read scheduler and
//               its environment (CSR block, c0Tx/c1Tx muxing, FIU responses).
// Revision    : 1.0 - initial release
// ============================================================================
interface grayscale_rd_sched_if #(
  parameter int ADDR_W = 42,
  parameter int SIZE_W = 32,
  parameter int TAG_W  = 5
);
  logic              start;
  logic [ADDR_W-1:0] src_base;
  logic [SIZE_W-1:0] num_lines;
  logic [ADDR_W-1:0] dsm_base;
  logic              c0_almfull;
  logic              rd_req_valid;
  logic [ADDR_W-1:0] rd_req_addr;
  logic [TAG_W-1:0]  rd_req_tag;
  logic              rd_rsp_valid;
  logic              wr_done_valid;
  logic [ADDR_W-1:0] wr_done_addr;
  logic [SIZE_W-1:0] wr_done_data;
  logic              wr_done_ack;
  logic              busy;
  logic              done;
  logic              err_unexpected;

  modport master (
    input  start, src_base, num_lines, dsm_base, c0_almfull,
           rd_rsp_valid, wr_done_ack,
    output rd_req_valid, rd_req_addr, rd_req_tag,
           wr_done_valid, wr_done_addr, wr_done_data,
           busy, done, err_unexpected
  );

  modport slave (
    output start, src_base, num_lines, dsm_base, c0_almfull,
           rd_rsp_valid, wr_done_ack,
    input  rd_req_valid, rd_req_addr, rd_req_tag,
           wr_done_valid, wr_done_addr, wr_done_data,
           busy, done, err_unexpected
  );
endinterface
`default_nettype wire

// File: rtl/grayscale_rd_sched.sv
`default_nettype none
// ============================================================================
// Module      : grayscale_rd_sched
// Description : Issues one read per source cache line under almost-full and
//               outstanding-credit throttling, then posts a DSM completion.
// Revision    : 1.0 - initial release
// ============================================================================
module grayscale_rd_sched #(
  parameter int ADDR_W          = 42,
  parameter int SIZE_W          = 32,
  parameter int MAX_OUTSTANDING = 32,
  parameter int TAG_W           = $clog2(MAX_OUTSTANDING)
) (
  input  wire logic               clk,
  input  wire logic               reset_n,
  grayscale_rd_sched_if.master    sched_if
);

  localparam int                OUT_W     = TAG_W + 1;
  localparam logic [OUT_W-1:0]  c_MAX_OUT = OUT_W'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_REPORT = 2'd3
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] r_dsm;
  logic [SIZE_W-1:0] r_num;
  logic [SIZE_W-1:0] r_issued;
  logic [SIZE_W-1:0] r_received;
  logic [OUT_W-1:0]  r_outstanding;
  logic              r_rd_req_valid;
  logic [ADDR_W-1:0] r_rd_req_addr;
  logic [TAG_W-1:0]  r_rd_req_tag;
  logic              r_wr_done_valid;
  logic [ADDR_W-1:0] r_wr_done_addr;
  logic [SIZE_W-1:0] r_wr_done_data;
  logic              r_busy;
  logic              r_done;
  logic              r_err;

  // An accepted start restarts all counters, so the first request can be
  // issued on the very edge that latches the command.
  logic              w_start_acc;
  logic              w_issue;
  logic [SIZE_W-1:0] w_issued_base;
  logic [SIZE_W-1:0] w_issued_nxt;
  logic [SIZE_W-1:0] w_rcv_base;
  logic [OUT_W-1:0]  w_out_base;
  logic [ADDR_W-1:0] w_addr_base;
  logic              w_rsp_ok;
  logic              w_rsp_err;

  assign w_start_acc   = (r_state == ST_IDLE) && sched_if.start;
  assign w_issued_base = w_start_acc ? '0 : r_issued;
  assign w_rcv_base    = w_start_acc ? '0 : r_received;
  assign w_out_base    = w_start_acc ? '0 : r_outstanding;
  assign w_addr_base   = w_start_acc ? sched_if.src_base : r_src;

  assign w_issue = !sched_if.c0_almfull &&
                   ((w_start_acc && (sched_if.num_lines != '0)) ||
                    ((r_state == ST_ISSUE) && (r_issued < r_num) &&
                     (r_outstanding < c_MAX_OUT)));

  assign w_issued_nxt = w_issued_base + SIZE_W'(w_issue);
  assign w_rsp_ok     = sched_if.rd_rsp_valid && ((w_out_base != '0) || w_issue);
  assign w_rsp_err    = sched_if.rd_rsp_valid && !w_rsp_ok;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state         <= ST_IDLE;
      r_src           <= '0;
      r_dsm           <= '0;
      r_num           <= '0;
      r_issued        <= '0;
      r_received      <= '0;
      r_outstanding   <= '0;
      r_rd_req_valid  <= 1'b0;
      r_rd_req_addr   <= '0;
      r_rd_req_tag    <= '0;
      r_wr_done_valid <= 1'b0;
      r_wr_done_addr  <= '0;
      r_wr_done_data  <= '0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_err           <= 1'b0;
    end else begin
      r_rd_req_valid <= w_issue;
      if (w_issue) begin
        r_rd_req_addr <= w_addr_base + ADDR_W'(w_issued_base);
        r_rd_req_tag  <= w_issued_base[TAG_W-1:0];
      end
      r_issued      <= w_issued_nxt;
      r_outstanding <= w_out_base + OUT_W'(w_issue) - OUT_W'(w_rsp_ok);
      r_received    <= w_rcv_base + SIZE_W'(w_rsp_ok && (r_state != ST_IDLE));
      if (w_rsp_err) begin
        r_err <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          if (sched_if.start) begin
            r_src  <= sched_if.src_base;
            r_num  <= sched_if.num_lines;
            r_dsm  <= sched_if.dsm_base;
            r_done <= 1'b0;
            r_busy <= 1'b1;
            if (sched_if.num_lines == '0) begin
              r_state         <= ST_REPORT;
              r_wr_done_valid <= 1'b1;
              r_wr_done_addr  <= sched_if.dsm_base;
              r_wr_done_data  <= '0;
            end else if (w_issued_nxt == sched_if.num_lines) begin
              r_state <= ST_DRAIN;
            end else begin
              r_state <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          if (w_issued_nxt == r_num) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if ((r_outstanding == '0) && (r_received == r_num)) begin
            r_state         <= ST_REPORT;
            r_wr_done_valid <= 1'b1;
            r_wr_done_addr  <= r_dsm;
            r_wr_done_data  <= r_received;
          end
        end
        ST_REPORT: begin
          if (sched_if.wr_done_ack) begin
            r_state         <= ST_IDLE;
            r_wr_done_valid <= 1'b0;
            r_done          <= 1'b1;
            r_busy          <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign sched_if.rd_req_valid   = r_rd_req_valid;
  assign sched_if.rd_req_addr    = r_rd_req_addr;
  assign sched_if.rd_req_tag     = r_rd_req_tag;
  assign sched_if.wr_done_valid  = r_wr_done_valid;
  assign sched_if.wr_done_addr   = r_wr_done_addr;
  assign sched_if.wr_done_data   = r_wr_done_data;
  assign sched_if.busy           = r_busy;
  assign sched_if.done           = r_done;
  assign sched_if.err_unexpected = r_err;

endmodule
`default_nettype wire

// File: tb/tb_grayscale_rd_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_grayscale_rd_sched
// Description : Directed and randomized transfers against a transaction-level
//               model of the read scheduler (4-credit configuration).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_grayscale_rd_sched;
  localparam int AW   = 42;
  localparam int SW   = 32;
  localparam int MAXO = 4;
  localparam int TW   = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  bit   exp_err = 1'b0;

  always #5 clk = ~clk;

  grayscale_rd_sched_if #(.ADDR_W(AW), .SIZE_W(SW), .TAG_W(TW)) bus ();

  grayscale_rd_sched #(
    .ADDR_W(AW), .SIZE_W(SW), .MAX_OUTSTANDING(MAXO), .TAG_W(TW)
  ) u_dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .sched_if (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.start        = 1'b0;
    bus.src_base     = '0;
    bus.num_lines    = '0;
    bus.dsm_base     = '0;
    bus.c0_almfull   = 1'b0;
    bus.rd_rsp_valid = 1'b0;
    bus.wr_done_ack  = 1'b0;
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_req_valid"}, bus.rd_req_valid, 0);
    chk({pfx, "_req_addr"},  bus.rd_req_addr, 0);
    chk({pfx, "_req_tag"},   bus.rd_req_tag, 0);
    chk({pfx, "_wr_valid"},  bus.wr_done_valid, 0);
    chk({pfx, "_wr_addr"},   bus.wr_done_addr, 0);
    chk({pfx, "_wr_data"},   bus.wr_done_data, 0);
    chk({pfx, "_busy"},      bus.busy, 0);
    chk({pfx, "_done"},      bus.done, 0);
    chk({pfx, "_err"},       bus.err_unexpected, 0);
  endtask

  // One full transfer: the model expects requests src+k / tag k%MAXO for
  // k = 0..num-1, never in a cycle gated by almfull, never more than MAXO
  // in flight, and the completion two cycles after the final response.
  task automatic run_xfer(input logic [AW-1:0] src, input logic [SW-1:0] num,
                          input logic [AW-1:0] dsm, input int af_pct,
                          input int af_from, input int af_len,
                          input int dmin, input int dmax,
                          input bit consec, input bit restart);
    int cyc, k, pend, last_rsp, last_due, wr_cyc, nd;
    int due[$];
    bit prev_af, af, fin;
    logic [AW-1:0] ea;
    cyc = 0; k = 0; pend = 0; last_rsp = -1; last_due = -1; wr_cyc = -1; fin = 1'b0;
    @(negedge clk);
    bus.start        = 1'b1;
    bus.src_base     = src;
    bus.num_lines    = num;
    bus.dsm_base     = dsm;
    bus.rd_rsp_valid = 1'b0;
    bus.wr_done_ack  = 1'b0;
    af = ($urandom_range(0, 99) < af_pct);
    bus.c0_almfull = af;
    prev_af = af;
    while (!fin) begin
      @(negedge clk);
      cyc++;
      bus.start = restart && (cyc == 2);
      if (restart && cyc == 2) begin
        bus.num_lines = num + 5;
        bus.src_base  = src + 100;
      end
      chk("busy", bus.busy, 1);
      chk("done_low", bus.done, 0);
      if (bus.rd_req_valid) begin
        chk("req_gate", prev_af, 0);
        chk("req_within_count", k < num, 1);
        ea = src + AW'(k);
        chk("req_addr", bus.rd_req_addr, ea);
        chk("req_tag", bus.rd_req_tag, k % MAXO);
        if (consec) chk("req_cycle", cyc, k + 1);
        k++;
        pend++;
        chk("in_flight", pend <= MAXO, 1);
        nd = cyc + $urandom_range(dmin, dmax);
        if (nd <= last_due) nd = last_due + 1;
        last_due = nd;
        due.push_back(nd);
      end
      if (wr_cyc >= 0) begin
        chk("wr_hold", bus.wr_done_valid, 1);
      end else if (bus.wr_done_valid) begin
        wr_cyc = cyc;
        chk("wr_latency", cyc, (num == 0) ? 1 : last_rsp + 2);
        chk("wr_all_issued", k, num);
        chk("wr_addr", bus.wr_done_addr, dsm);
        chk("wr_data", bus.wr_done_data, num);
      end
      bus.rd_rsp_valid = 1'b0;
      if (due.size() > 0 && due[0] <= cyc) begin
        bus.rd_rsp_valid = 1'b1;
        void'(due.pop_front());
        pend--;
        last_rsp = cyc;
      end
      af = ($urandom_range(0, 99) < af_pct) || (cyc >= af_from && cyc < af_from + af_len);
      bus.c0_almfull = af;
      prev_af = af;
      bus.wr_done_ack = (wr_cyc >= 0) && (($urandom_range(0, 2) == 0) || cyc >= wr_cyc + 3);
      if (bus.wr_done_ack) begin
        @(negedge clk);
        idle_inputs();
        chk("done_set", bus.done, 1);
        chk("busy_clear", bus.busy, 0);
        chk("wr_drop", bus.wr_done_valid, 0);
        chk("err_flag", bus.err_unexpected, exp_err);
        chk("req_total", k, num);
        fin = 1'b1;
      end else if (cyc > 3000) begin
        checks++;
        errors++;
        $error("FAIL timeout observed=cycle %0d expected=completion", cyc);
        fin = 1'b1;
      end
    end
  endtask

  initial begin
    int cnt, at;
    logic [63:0] rnd;
    logic [AW-1:0] rsrc;
    idle_inputs();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("rst");
    reset_n = 1'b1;

    run_xfer(42'h1000, 4, 42'h0ABC, 0, -1, 0, 5, 5, 1'b1, 1'b0);
    run_xfer(42'h2000, 0, 42'h0DEF, 0, -1, 0, 1, 1, 1'b1, 1'b0);
    run_xfer(42'h4000, 8, 42'h0111, 0, 3, 3, 2, 4, 1'b0, 1'b0);

    // Response with nothing in flight while idle.
    @(negedge clk);
    bus.rd_rsp_valid = 1'b1;
    @(negedge clk);
    bus.rd_rsp_valid = 1'b0;
    exp_err = 1'b1;
    chk("err_set", bus.err_unexpected, 1);
    repeat (3) @(negedge clk);
    chk("err_sticky", bus.err_unexpected, 1);
    chk("err_idle_busy", bus.busy, 0);

    run_xfer(42'h5000, 3, 42'h0222, 0, -1, 0, 3, 6, 1'b0, 1'b1);

    for (int n = 0; n < 6; n++) begin
      rnd  = {$urandom, $urandom};
      rsrc = (n == 0) ? {AW{1'b1}} - AW'(2) : rnd[AW-1:0];
      run_xfer(rsrc, SW'($urandom_range(0, 12)), AW'($urandom), 25, -1, 0, 1, 10, 1'b0, 1'b0);
    end

    // Credit exhaustion with responses withheld.
    @(negedge clk);
    bus.start = 1'b1; bus.src_base = 42'h2000; bus.num_lines = 10; bus.dsm_base = 42'h333;
    cnt = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.rd_req_valid) begin
        chk("stall_addr", bus.rd_req_addr, 42'h2000 + AW'(cnt));
        cnt++;
      end
    end
    chk("stall_count", cnt, MAXO);
    bus.rd_rsp_valid = 1'b1;
    cnt = 0; at = -1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      bus.rd_rsp_valid = 1'b0;
      if (bus.rd_req_valid) begin
        cnt++;
        at = i;
        chk("credit_addr", bus.rd_req_addr, 42'h2004);
      end
    end
    chk("credit_count", cnt, 1);
    chk("credit_latency", at, 2);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk_all_zero("stall_rst");
    reset_n = 1'b1;
    exp_err = 1'b0;

    // Reset while draining three reads.
    @(negedge clk);
    bus.start = 1'b1; bus.src_base = 42'h6000; bus.num_lines = 3; bus.dsm_base = 42'h444;
    cnt = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.rd_req_valid) cnt++;
    end
    chk("drain_reqs", cnt, 3);
    chk("drain_busy", bus.busy, 1);
    reset_n = 1'b0;
    @(negedge clk);
    chk_all_zero("drain_rst");
    reset_n = 1'b1;
    idle_inputs();

    run_xfer(42'h7000, 2, 42'h0555, 0, -1, 0, 1, 3, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
